// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial ripple subtractor, LSB first.
// One full-subtractor cell and a borrow flop process one bit per clock;
// operands load on an accepted start, and the completed difference and
// borrow-out are presented with a one-cycle done strobe.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             input_borrow,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             output_borrow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    // Full subtractor cell: returns {borrow_out, difference_bit}.
    function automatic logic [1:0] full_sub(
        input logic ai,
        input logic bi,
        input logic br
    );
        logic d;
        logic bo;
        d  = ai ^ bi ^ br;
        bo = (~ai & bi) | (~(ai ^ bi) & br);
        return {bo, d};
    endfunction

    logic [1:0]       state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_r;
    logic             borrow_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] difference_r;
    logic             output_borrow_r;

    logic [1:0]       cell_s;
    logic             diff_bit_s;
    logic             borrow_next_s;
    logic [WIDTH-1:0] res_next_s;

    // Current bit through the subtractor cell and the next result image.
    always_comb begin
        cell_s        = full_sub(a_sh_r[0], b_sh_r[0], borrow_r);
        diff_bit_s    = cell_s[0];
        borrow_next_s = cell_s[1];
        res_next_s    = res_r >> 1;
        res_next_s[WIDTH-1] = diff_bit_s;
    end

    // Control FSM, operand shift registers, borrow flop and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            cnt_r           <= {CW{1'b0}};
            a_sh_r          <= {WIDTH{1'b0}};
            b_sh_r          <= {WIDTH{1'b0}};
            res_r           <= {WIDTH{1'b0}};
            borrow_r        <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            difference_r    <= {WIDTH{1'b0}};
            output_borrow_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_sh_r   <= a;
                        b_sh_r   <= b;
                        borrow_r <= input_borrow;
                        res_r    <= {WIDTH{1'b0}};
                        cnt_r    <= {CW{1'b0}};
                        busy_r   <= 1'b1;
                        state_r  <= ST_RUN;
                    end else begin
                        busy_r   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sh_r   <= a_sh_r >> 1;
                    b_sh_r   <= b_sh_r >> 1;
                    res_r    <= res_next_s;
                    borrow_r <= borrow_next_s;
                    cnt_r    <= cnt_r + CW'(1);
                    busy_r   <= 1'b1;
                    if (cnt_r == LAST_BIT) begin
                        difference_r    <= res_next_s;
                        output_borrow_r <= borrow_next_s;
                        done_r          <= 1'b1;
                        state_r         <= ST_DONE;
                    end else begin
                        done_r          <= 1'b0;
                        state_r         <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    // Always return to IDLE; a start seen here is dropped.
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign difference    = difference_r;
    assign output_borrow = output_borrow_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: an 8-bit instance for the
// main scenarios and a 1-bit instance for the full-subtractor truth table.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       reset8, start8, bin8, busy8, done8, ob8;
    logic [7:0] a8, b8, diff8;
    logic       reset1, start1, bin1, busy1, done1, ob1;
    logic [0:0] a1, b1, diff1;

    int checks = 0;
    int errors = 0;

    logic [8:0] q8 [$];
    logic [1:0] q1 [$];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset8), .start(start8), .a(a8), .b(b8),
        .input_borrow(bin8), .busy(busy8), .done(done8),
        .difference(diff8), .output_borrow(ob8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset1), .start(start1), .a(a1), .b(b1),
        .input_borrow(bin1), .busy(busy1), .done(done1),
        .difference(diff1), .output_borrow(ob1)
    );

    // Drive a one-cycle start on the 8-bit instance and push the expected result.
    task automatic start_op8(input logic [7:0] av, input logic [7:0] bv, input logic bi);
        logic [8:0] r;
        @(negedge clk);
        a8 = av; b8 = bv; bin8 = bi; start8 = 1'b1;
        r = {1'b0, av} - {1'b0, bv} - {8'd0, bi};
        q8.push_back(r);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    // Wait for done (bounded), counting latency and busy cycles, and score the result.
    task automatic await8(input bit scramble, output int lat, output int bcnt);
        logic [8:0] e;
        lat = 0;
        bcnt = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            if (busy8 === 1'b1) bcnt++;
            if (scramble && lat == 2) begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
                bin8 = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            lat++;
        end
        if (busy8 === 1'b1) bcnt++;
        checks++;
        if (done8 !== 1'b1) begin
            errors++;
            $display("FAIL done8_timeout: done=%b after %0d cycles, required 1", done8, lat);
        end else if (q8.size() == 0) begin
            errors++;
            $display("FAIL scoreboard8_empty: done seen with no expected entry");
        end else begin
            e = q8.pop_front();
            if ({ob8, diff8} !== e) begin
                errors++;
                $display("FAIL result8: got borrow=%b diff=%h, required borrow=%b diff=%h",
                         ob8, diff8, e[8], e[7:0]);
            end
        end
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({busy8, done8, diff8, ob8} !== 11'd0 || {busy1, done1, diff1, ob1} !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: w8=%b%b%h%b w1=%b%b%b%b, required all 0",
                     busy8, done8, diff8, ob8, busy1, done1, diff1, ob1);
        end
        @(negedge clk);
        reset8 = 1'b0;
        reset1 = 1'b0;
    endtask

    task automatic test_basic;
        int lat, bcnt;
        start_op8(8'h5A, 8'h23, 1'b0);
        await8(1'b0, lat, bcnt);
        checks++;
        if (lat != 8) begin
            errors++;
            $display("FAIL basic_latency: done at %0d cycles after accept edge, required 8", lat);
        end
        @(negedge clk);
        checks++;
        if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL basic_strobe: done=%b busy=%b, required 0 0", done8, busy8);
        end
        checks++;
        if (bcnt != 9) begin
            errors++;
            $display("FAIL basic_busy_len: busy for %0d cycles, required 9", bcnt);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (diff8 !== 8'h37 || ob8 !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold: diff=%h borrow=%b, required 37 0", diff8, ob8);
        end
    endtask

    task automatic test_borrow;
        int lat, bcnt;
        start_op8(8'h00, 8'h01, 1'b0);
        await8(1'b0, lat, bcnt);
        start_op8(8'hFF, 8'hFF, 1'b1);
        await8(1'b0, lat, bcnt);
        start_op8(8'h10, 8'h0F, 1'b1);
        await8(1'b1, lat, bcnt);
        start_op8(8'h3C, 8'hA7, 1'b1);
        await8(1'b1, lat, bcnt);
    endtask

    task automatic test_ignore_start;
        int pulses = 0;
        int lat = -1;
        logic [8:0] e;
        start_op8(8'hC3, 8'h3C, 1'b0);
        for (int i = 0; i < 30; i++) begin
            if (done8 === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    lat = i;
                    e = q8.pop_front();
                    checks++;
                    if ({ob8, diff8} !== e) begin
                        errors++;
                        $display("FAIL ignore_result: got %b/%h, required %b/%h",
                                 ob8, diff8, e[8], e[7:0]);
                    end
                end
            end
            start8 = (i == 3) || (done8 === 1'b1);
            @(negedge clk);
        end
        start8 = 1'b0;
        checks++;
        if (pulses != 1 || lat != 8) begin
            errors++;
            $display("FAIL ignore_pulses: %0d done pulses first at %0d, required 1 at 8", pulses, lat);
        end
        checks++;
        if (busy8 !== 1'b0) begin
            errors++;
            $display("FAIL ignore_idle: busy=%b, required 0", busy8);
        end
    endtask

    task automatic test_back_to_back;
        int t [2];
        int n = 0;
        logic [8:0] e;
        @(negedge clk);
        a8 = 8'h81; b8 = 8'h92; bin8 = 1'b0; start8 = 1'b1;
        q8.push_back(9'h1EF);
        q8.push_back(9'h1EF);
        for (int i = 0; i < 40 && n < 2; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) begin
                t[n] = i;
                n++;
                e = q8.pop_front();
                checks++;
                if ({ob8, diff8} !== e) begin
                    errors++;
                    $display("FAIL b2b_result: got %b/%h, required %b/%h", ob8, diff8, e[8], e[7:0]);
                end
                if (n == 2) start8 = 1'b0;
            end
        end
        start8 = 1'b0;
        checks++;
        if (n != 2 || t[1] - t[0] != 10) begin
            errors++;
            $display("FAIL b2b_spacing: %0d pulses spacing %0d, required 2 spacing 10", n, t[1] - t[0]);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy8 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b, required 0", busy8);
        end
    endtask

    task automatic test_async_reset;
        int lat, bcnt;
        logic [8:0] e;
        start_op8(8'h5A, 8'h23, 1'b0);
        repeat (4) @(negedge clk);
        #2 reset8 = 1'b1;
        #1;
        checks++;
        if ({busy8, done8, diff8, ob8} !== 11'd0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b diff=%h borrow=%b, required all 0",
                     busy8, done8, diff8, ob8);
        end
        e = q8.pop_front();
        @(negedge clk);
        reset8 = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard: done=%b busy=%b, required 0 0", done8, busy8);
        end
        start_op8(8'h5A, 8'h23, 1'b0);
        await8(1'b0, lat, bcnt);
    endtask

    task automatic test_width1;
        logic [1:0] tt [8];
        logic [2:0] v;
        logic [1:0] e;
        int lat;
        tt = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            @(negedge clk);
            a1 = v[2]; b1 = v[1]; bin1 = v[0]; start1 = 1'b1;
            q1.push_back(tt[i]);
            @(negedge clk);
            start1 = 1'b0;
            lat = 0;
            while (done1 !== 1'b1 && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            e = q1.pop_front();
            checks++;
            if (done1 !== 1'b1 || lat != 1 || {diff1, ob1} !== e) begin
                errors++;
                $display("FAIL w1_truth_%0d: done=%b lat=%0d d,bout=%b%b, required 1 1 %b",
                         i, done1, lat, diff1, ob1, e);
            end
        end
    endtask

    initial begin
        reset8 = 1'b1; start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;
        reset1 = 1'b1; start1 = 1'b0; a1 = 1'b0;  b1 = 1'b0;  bin1 = 1'b0;
        test_reset();
        test_basic();
        test_borrow();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        test_width1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
